lsu: RTL and testbench

- Load/store unit: the initiator that drives the word-addressed data memory on behalf of the core.
- Accepts one RV32I load or store request at a time.
- Splits byte/half accesses onto the full-word memory port. Sub-word stores use read-modify-write, because the memory writes whole words only.
- Returns sign- or zero-extended load data, or a fault, through a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 106 ++++++++++
 tb/tb_lsu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, sizes and the request fault check for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;
    localparam int unsigned MEM_SIZE = 256;
    localparam int unsigned ADDR_W   = $clog2(MEM_SIZE);

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [LSU_XLEN-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        RESP
    } lsu_state_e;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_funct3_e;

    typedef struct packed {
        logic                we;
        logic [2:0]          funct3;
        logic [LSU_XLEN-1:0] addr;
        logic [LSU_XLEN-1:0] wdata;
    } lsu_req_t;

    // Illegal funct3, misaligned half/word, or word index beyond the memory.
    function automatic logic lsu_fault(input lsu_req_t req, input int unsigned words);
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = req.we ? (req.funct3 > 3'd2)
                        : (req.funct3 == 3'd3 || req.funct3[2:1] == 2'b11);
        misal  = (req.funct3[1:0] == 2'b01 && req.addr[0])
              || (req.funct3[1:0] == 2'b10 && req.addr[1:0] != 2'b00);
        oor    = {2'b00, req.addr[LSU_XLEN-1:2]} >= words;
        return bad_f3 | misal | oor;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  data_t      i_word,
    input  data_t      i_wdata,
    input  logic [1:0] i_off,
    input  logic [2:0] i_funct3,
    output data_t      o_load,
    output data_t      o_store
);

    data_t      w_shifted;
    logic [4:0] w_bsh;
    logic [4:0] w_hsh;

    assign w_bsh     = {i_off, 3'b000};
    assign w_hsh     = {i_off[1], 4'b0000};
    assign w_shifted = i_word >> (i_off[1] ? 5'd16 : 5'd0) >> (i_off[0] ? 5'd8 : 5'd0);

    always_comb begin
        o_load = i_word;
        case (i_funct3)
            LB:      o_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LBU:     o_load = {24'b0, w_shifted[7:0]};
            LH:      o_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LHU:     o_load = {16'b0, w_shifted[15:0]};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_store = i_wdata;
        case (i_funct3)
            3'd0:    o_store = (i_word & ~(32'h0000_00FF << w_bsh))
                             | ({24'b0, i_wdata[7:0]} << w_bsh);
            3'd1:    o_store = (i_word & ~(32'h0000_FFFF << w_hsh))
                             | ({16'b0, i_wdata[15:0]} << w_hsh);
            default: o_store = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time onto a word-wide memory port,
// with read-modify-write for byte and halfword stores.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = LSU_XLEN,
    parameter int unsigned MEM_WORDS = MEM_SIZE
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_fault,
    output addr_t           o_mem_address,
    output data_t           o_mem_data_write,
    output logic            o_mem_write_en,
    input  data_t           i_mem_data
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    lsu_req_t        r_req;
    lsu_req_t        w_req_in;
    logic            w_accept;
    logic            w_fault_in;
    logic [XLEN-1:0] r_rdata;
    data_t           r_mem_data_write;
    data_t           w_load_data;
    data_t           w_store_data;

    assign w_req_in   = '{we: i_req_we, funct3: i_req_funct3, addr: i_req_addr,
                          wdata: i_req_wdata};
    assign w_accept   = i_req_valid && (r_state == IDLE);
    assign w_fault_in = lsu_fault(w_req_in, MEM_WORDS);

    lsu_align u_align (
        .i_word   (i_mem_data),
        .i_wdata  (r_req.wdata),
        .i_off    (r_req.addr[1:0]),
        .i_funct3 (r_req.funct3),
        .o_load   (w_load_data),
        .o_store  (w_store_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault_in)              w_next = RESP;
                    else if (!i_req_we)          w_next = LOAD;
                    else if (i_req_funct3 == LW) w_next = WRITE;
                    else                         w_next = READ;
                end
            end
            LOAD:    w_next = RESP;
            READ:    w_next = WRITE;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Write strobe is gated by reset so an edge with reset low never writes.
    always_comb begin
        o_req_ready    = (r_state == IDLE);
        o_rsp_valid    = (r_state == RESP);
        o_rsp_fault    = (r_state == RESP) && lsu_fault(r_req, MEM_WORDS);
        o_mem_write_en = (r_state == WRITE) && i_rst_n;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req            <= '0;
            r_rdata          <= '0;
            r_mem_data_write <= '0;
        end else if (w_accept) begin
            r_req            <= w_req_in;
            r_rdata          <= '0;
            r_mem_data_write <= i_req_wdata;
        end else if (r_state == LOAD) begin
            r_rdata <= w_load_data;
        end else if (r_state == READ) begin
            r_mem_data_write <= w_store_data;
        end
    end

    assign o_rsp_rdata      = r_rdata;
    assign o_mem_address    = r_req.addr[ADDR_W+1:2];
    assign o_mem_data_write = r_mem_data_write;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu paired with a word-wide memory model.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    addr_t       mem_address;
    data_t       mem_data_write;
    logic        mem_write_en;
    data_t       mem_rdata;

    logic [31:0] mem [MEM_SIZE];
    logic        load_mem;
    int          checks;
    int          errors;

    lsu u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_we         (req_we),
        .i_req_funct3     (req_funct3),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_rdata      (rsp_rdata),
        .o_rsp_fault      (rsp_fault),
        .o_mem_address    (mem_address),
        .o_mem_data_write (mem_data_write),
        .o_mem_write_en   (mem_write_en),
        .i_mem_data       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];

    always @(posedge clk) begin
        if (load_mem) begin
            mem[1] <= 32'h8877_66F5;
            mem[2] <= 32'h0000_0000;
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_data_write;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: ready=%b required 1", req_ready);
        end
    endtask

    // Issues one request from IDLE and records latency, response and write strobes.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic fault, output int wrs, output int wr_at);
        wait_idle();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat   = 0;
        rdata = 32'hXXXX_XXXX;
        fault = 1'bx;
        wrs   = 0;
        wr_at = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_write_en) begin
                wrs++;
                wr_at = k;
            end
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                fault = rsp_fault;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        load_mem   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_write_en} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/fault/we=%b required 1000",
                     {req_ready, rsp_valid, rsp_fault, mem_write_en});
        end
        checks++;
        if (rsp_rdata !== 32'd0 || mem_address !== '0 || mem_data_write !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                     rsp_rdata, mem_address, mem_data_write);
        end
        load_mem = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] ads [4] = '{32'h7, 32'h4, 32'h6, 32'h6};
        logic [31:0] exp [4] = '{32'hFFFF_FF88, 32'h0000_00F5, 32'hFFFF_8877, 32'h0000_8877};
        int lat, wrs, wr_at;
        logic [31:0] rd;
        logic f;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, f, wrs, wr_at);
            checks++;
            if (lat != 2 || rd !== exp[i] || f !== 1'b0 || wrs != 0) begin
                errors++;
                $display("FAIL load_%0d: lat=%0d rdata=%h fault=%b wrs=%0d required 2 %h 0 0",
                         i, lat, rd, f, wrs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_in_write();
        req_valid  = 1'b0;
        wait_idle();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h4;
        req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_en: write_en=%b required 0", mem_write_en);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_write_en} !== 4'b1000 ||
            rsp_rdata !== 32'd0 || mem_address !== '0 || mem_data_write !== 32'd0) begin
            errors++;
            $display("FAIL rst_outputs: rdy/val/flt/we=%b rdata=%h addr=%h wdata=%h req 1000 0",
                     {req_ready, rsp_valid, rsp_fault, mem_write_en}, rsp_rdata, mem_address,
                     mem_data_write);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem[1] !== 32'h8877_66F5) begin
            errors++;
            $display("FAIL rst_no_write: ready=%b mem1=%h required 1 887766f5", req_ready, mem[1]);
        end
    endtask

    task automatic test_sub_store();
        int lat, wrs, wr_at;
        logic [31:0] rd;
        logic f;
        do_req(1'b1, 3'd0, 32'h5, 32'h1234_56AB, lat, rd, f, wrs, wr_at);
        checks++;
        if (lat != 3 || wrs != 1 || wr_at != 2 || f !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sb_timing: lat=%0d wrs=%0d wr_at=%0d fault=%b rdata=%h req 3 1 2 0 0",
                     lat, wrs, wr_at, f, rd);
        end
        checks++;
        if (mem[1] !== 32'h8877_ABF5) begin
            errors++;
            $display("FAIL sb_merge: mem1=%h required 8877abf5", mem[1]);
        end
        do_req(1'b0, 3'd2, 32'h4, 32'h0, lat, rd, f, wrs, wr_at);
        checks++;
        if (lat != 2 || rd !== 32'h8877_ABF5 || f !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_sb: lat=%0d rdata=%h fault=%b required 2 8877abf5 0",
                     lat, rd, f);
        end
    endtask

    task automatic test_faults();
        logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
        logic [31:0] ads [4] = '{32'h2, 32'h3, 32'h4, 32'(4 * MEM_SIZE)};
        int lat, wrs, wr_at;
        logic [31:0] rd;
        logic f;
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], f3s[i], ads[i], 32'hCAFE_F00D, lat, rd, f, wrs, wr_at);
            checks++;
            if (lat != 1 || f !== 1'b1 || rd !== 32'd0 || wrs != 0) begin
                errors++;
                $display("FAIL fault_%0d: lat=%0d fault=%b rdata=%h wrs=%0d required 1 1 0 0",
                         i, lat, f, rd, wrs);
            end
        end
        checks++;
        if (mem[1] !== 32'h8877_ABF5) begin
            errors++;
            $display("FAIL fault_mem: mem1=%h required 8877abf5", mem[1]);
        end
    endtask

    // Valid held high; LW word 1 and SW word 2 alternate, each taking 3 cycles IDLE..RESP.
    task automatic test_back_to_back();
        int accepts, comps, bad;
        accepts = 0;
        comps   = 0;
        bad     = 0;
        wait_idle();
        for (int p = 0; p < 36; p++) begin
            if (p > 0) @(negedge clk);
            if (req_ready !== (p % 3 == 0) || rsp_valid !== (p % 3 == 2)) begin
                bad++;
                $display("FAIL b2b_cycle_%0d: ready=%b rsp=%b required %b %b", p, req_ready,
                         rsp_valid, (p % 3 == 0), (p % 3 == 2));
            end
            if (rsp_valid) begin
                comps++;
                if (((p / 3) % 2 == 0 && rsp_rdata !== 32'h8877_ABF5) ||
                    ((p / 3) % 2 == 1 && rsp_rdata !== 32'd0)) begin
                    bad++;
                    $display("FAIL b2b_rdata_%0d: rdata=%h", p / 3, rsp_rdata);
                end
            end
            if (req_ready) begin
                accepts++;
                req_valid  = 1'b1;
                req_we     = ((p / 3) % 2 == 1);
                req_funct3 = 3'd2;
                req_addr   = ((p / 3) % 2 == 1) ? 32'h8 : 32'h4;
                req_wdata  = 32'hA500_0000 | 32'(p);
            end
        end
        req_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_pattern: bad cycles=%0d required 0", bad);
        end
        checks++;
        if (accepts != 12 || comps != 12) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d comps=%0d required 12 12", accepts, comps);
        end
        @(negedge clk);
        checks++;
        if (mem[2] !== (32'hA500_0000 | 32'd33)) begin
            errors++;
            $display("FAIL b2b_last_sw: mem2=%h required %h", mem[2], 32'hA500_0000 | 32'd33);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_loads();
        test_reset_in_write();
        test_sub_store();
        test_faults();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
